// File: rtl/klein_stream_ctrl.sv
// klein_stream_ctrl: stream-side sequencer for the KLEIN-64 cipher core.
// Takes plaintext blocks on a valid/ready input, starts the core, waits for
// completion under a watchdog, then holds the ciphertext on a valid/ready output.
// Define KLEIN_CBC_EN to build with CBC chaining; the default build is ECB.
module klein_stream_ctrl #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             iclk,
    input  logic             ireset_n,
    input  logic             key_we,
    input  logic [63:0]      ikey,
    input  logic             iv_we,
    input  logic [63:0]      iiv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             core_start,
    output logic [63:0]      core_block,
    output logic [63:0]      core_key,
    input  logic             core_ready,
    input  logic [63:0]      core_result,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err_cfg,
    output logic             err_tmo,
    input  logic             err_clr
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

    state_t            r_state, w_next;
    logic [63:0]       r_key, r_blk, r_res;
    logic [WD_W-1:0]   r_wdog;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_cfg, r_err_tmo;
    logic              w_idle, w_cfg_wr, w_accept, w_wd_exp, w_out_hs;
    logic [63:0]       w_blk_in;

`ifdef KLEIN_CBC_EN
    logic [63:0]       r_chain;
    assign w_cfg_wr = key_we | iv_we;
    assign w_blk_in = in_data ^ r_chain;
`else
    // ECB build: the IV port has no function at all.
    logic              w_unused_iv;
    assign w_unused_iv = iv_we ^ (^iiv);
    assign w_cfg_wr    = key_we;
    assign w_blk_in    = in_data;
`endif

    assign w_idle     = (r_state == S_IDLE);
    // A config write owns the IDLE cycle; the block waits one cycle.
    assign in_ready   = w_idle & ireset_n & ~w_cfg_wr;
    assign w_accept   = in_valid & in_ready;
    assign w_wd_exp   = (r_wdog == WD_W'(TIMEOUT - 1));
    assign out_valid  = (r_state == S_HOLD);
    assign w_out_hs   = out_valid & out_ready;
    assign out_data   = r_res;
    assign core_start = (r_state == S_START);
    assign core_block = r_blk;
    assign core_key   = r_key;
    assign busy       = ~w_idle;
    assign blk_cnt    = r_cnt;
    assign err_cfg    = r_err_cfg;
    assign err_tmo    = r_err_tmo;

    // State register.
    always_ff @(posedge iclk) begin
        if (!ireset_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Next-state: core_ready only matters in WAIT (it is stale-high in START).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (core_ready) w_next = S_HOLD;
                     else if (w_wd_exp) w_next = S_IDLE;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: key, block, result, watchdog and completed-block counter.
    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            r_key  <= '0;
            r_blk  <= '0;
            r_res  <= '0;
            r_wdog <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_idle && key_we) r_key <= ikey;
            if (w_accept) r_blk <= w_blk_in;
            if (r_state == S_START) r_wdog <= '0;
            else if (r_state == S_WAIT && !core_ready) r_wdog <= r_wdog + WD_W'(1);
            if (r_state == S_WAIT && core_ready) r_res <= core_result;
            if (w_out_hs) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sticky errors; a new error beats a simultaneous clear.
    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            r_err_cfg <= 1'b0;
            r_err_tmo <= 1'b0;
        end else begin
            if (w_cfg_wr && !w_idle) r_err_cfg <= 1'b1;
            else if (err_clr)        r_err_cfg <= 1'b0;
            if (r_state == S_WAIT && !core_ready && w_wd_exp) r_err_tmo <= 1'b1;
            else if (err_clr)                                 r_err_tmo <= 1'b0;
        end
    end

`ifdef KLEIN_CBC_EN
    // Chain: loaded from the IV in IDLE, then follows each delivered ciphertext.
    always_ff @(posedge iclk) begin
        if (!ireset_n)             r_chain <= '0;
        else if (w_idle && iv_we)  r_chain <= iiv;
        else if (w_out_hs)         r_chain <= r_res;
    end
`endif

endmodule

// File: tb/tb_klein_stream_ctrl.sv
// Directed bench for klein_stream_ctrl with a behavioural KLEIN core model
// (ready 13 cycles after start, result a fixed function of block and key).
module tb_klein_stream_ctrl;
    localparam int TMO = 32;
    localparam int CW  = 4;

    logic          iclk = 1'b0;
    logic          ireset_n = 1'b0;
    logic          key_we = 1'b0, iv_we = 1'b0, in_valid = 1'b0, out_ready = 1'b1, err_clr = 1'b0;
    logic [63:0]   ikey = '0, iiv = '0, in_data = '0;
    logic          in_ready, out_valid, core_start, busy, err_cfg, err_tmo;
    logic [63:0]   out_data, core_block, core_key;
    logic          core_ready = 1'b1;
    logic [63:0]   core_result = '0;
    logic [CW-1:0] blk_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0]   key_m = '0, chain_m = '0;
    logic [CW-1:0] cnt_m = '0;
    logic          m_noready = 1'b0;
    int            m_cnt = 0;

    always #5 iclk = ~iclk;

    klein_stream_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .key_we(key_we), .ikey(ikey), .iv_we(iv_we), .iiv(iiv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .core_start(core_start), .core_block(core_block),
        .core_key(core_key), .core_ready(core_ready), .core_result(core_result), .busy(busy),
        .blk_cnt(blk_cnt), .err_cfg(err_cfg), .err_tmo(err_tmo), .err_clr(err_clr)
    );

    function automatic logic [63:0] fcore(input logic [63:0] b, input logic [63:0] k);
        return {b[31:0], b[63:32]} ^ k ^ 64'h5A5A_0F0F_3C3C_9696;
    endfunction

    // Core model: ready drops after start, rises 13 cycles after the start cycle.
    always @(posedge iclk) begin
        if (core_start) begin
            core_ready  <= 1'b0;
            core_result <= fcore(core_block, core_key);
            m_cnt       <= 1;
        end else if (m_cnt != 0) begin
            if (m_cnt == 12) begin
                core_ready <= !m_noready;
                m_cnt      <= 0;
            end else m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    // One block end to end; optional key_we+err_clr pulse during WAIT.
    task automatic send(input logic [63:0] p, input bit kpulse);
        logic [63:0] eb, er;
        int n, xs;
        bit ok;
        eb = p;
`ifdef KLEIN_CBC_EN
        eb = p ^ chain_m;
`endif
        er = fcore(eb, key_m);
        in_valid = 1'b1; in_data = p;
        #1;
        chk("in_ready idle", 64'(in_ready), 64'd1);
        tick;
        in_valid = 1'b0;
        chk("core_start", 64'(core_start), 64'd1);
        chk("core_block", core_block, eb);
        chk("core_key", core_key, key_m);
        n = 1; xs = 0;
        while (!out_valid && n < 60) begin
            tick; n++;
            if (core_start) xs++;
            if (kpulse && n == 5) begin
                key_we = 1'b1; ikey = ~key_m; err_clr = 1'b1;
                tick; n++;
                key_we = 1'b0; ikey = '0; err_clr = 1'b0;
                chk("err_cfg wait wr", 64'(err_cfg), 64'd1);
                chk("core_key held", core_key, key_m);
            end
        end
        chk("extra start", 64'(xs), 64'd0);
        chk("latency", 64'(n), 64'd15);
        chk("out_data", out_data, er);
        if (!out_ready) begin
            ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (!(out_valid === 1'b1 && out_data === er && in_ready === 1'b0)) ok = 1'b0;
                tick;
            end
            chk("hold stable", 64'(ok), 64'd1);
            out_ready = 1'b1;
        end
        tick;
        cnt_m   = cnt_m + CW'(1);
        chain_m = er;
        chk("blk_cnt", 64'(blk_cnt), 64'(cnt_m));
        chk("busy after", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        bit sawv;
        // Reset
        tick; tick;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst outs", {out_data ^ core_block ^ core_key}, 64'd0);
        chk("rst flags", {60'd0, out_valid, core_start, err_cfg, err_tmo}, 64'd0);
        chk("rst cnt", 64'(blk_cnt), 64'd0);
        ireset_n = 1'b1;
        tick;

        // 1: key load then one all-ones block
        key_we = 1'b1; ikey = 64'h0;
        tick;
        key_we = 1'b0; key_m = 64'h0;
        chk("key0", core_key, 64'h0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // 2: downstream stall in HOLD
        out_ready = 1'b0;
        send(64'h1122_3344_5566_7788, 1'b0);

        // 3: watchdog abort
        m_noready = 1'b1;
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
        tick;
        in_valid = 1'b0;
        chk("tmo start", 64'(core_start), 64'd1);
        n = 1; sawv = 1'b0;
        while (busy && n < 100) begin
            tick; n++;
            if (out_valid) sawv = 1'b1;
        end
        chk("tmo cycles", 64'(n), 64'(TMO + 2));
        chk("tmo no out", 64'(sawv), 64'd0);
        chk("err_tmo set", 64'(err_tmo), 64'd1);
        chk("tmo cnt", 64'(blk_cnt), 64'(cnt_m));
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_tmo clr", 64'(err_tmo), 64'd0);
        m_noready = 1'b0;

        // 4: config write during WAIT, then key_we colliding with in_valid
        send(64'h0F0F_0F0F_F0F0_F0F0, 1'b1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_cfg clr", 64'(err_cfg), 64'd0);
        key_we = 1'b1; ikey = 64'hCAFE_F00D_1234_5678; in_valid = 1'b1; in_data = 64'h55;
        #1;
        chk("in_ready cfg", 64'(in_ready), 64'd0);
        tick;
        key_we = 1'b0; key_m = 64'hCAFE_F00D_1234_5678;
        chk("key loaded", core_key, key_m);
        chk("not accepted", 64'(busy), 64'd0);
        send(64'h55, 1'b0);

        // 5: chaining (CBC) or pass-through (ECB)
`ifdef KLEIN_CBC_EN
        iv_we = 1'b1; iiv = 64'h0123_4567_89AB_CDEF;
        tick;
        iv_we = 1'b0; chain_m = 64'h0123_4567_89AB_CDEF;
`endif
        send(64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        send(64'h0000_0000_FFFF_0000, 1'b0);

        // 6: reset during WAIT, fresh block, counter wrap
        in_valid = 1'b1; in_data = 64'h77;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        ireset_n = 1'b0;
        tick;
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst flags", {59'd0, in_ready, out_valid, core_start, err_cfg, err_tmo}, 64'd0);
        chk("mid rst data", {out_data | core_block | core_key}, 64'd0);
        chk("mid rst cnt", 64'(blk_cnt), 64'd0);
        key_m = '0; chain_m = '0; cnt_m = '0;
        ireset_n = 1'b1;
        tick;
        send(64'h8000_0000_0000_0001, 1'b0);
        for (int i = 0; i < 14; i++) send({$urandom, $urandom}, 1'b0);
        chk("cnt max", 64'(blk_cnt), 64'd15);
        send(64'h1, 1'b0);
        chk("cnt wrap", 64'(blk_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
